screen_sequencer: RTL and testbench



---
 rtl/pong_pkg.sv | 19 +
 rtl/button_debounce.sv | 52 +++++
 rtl/screen_sequencer.sv | 151 +++++++++++++++
 tb/tb_screen_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared screen encodings and menu button geometry for the Pong display path
package pong_pkg;

    typedef enum logic [1:0] {
        SCR_MENU     = 2'd0,
        SCR_GAME     = 2'd1,
        SCR_CREDITS  = 2'd2,
        SCR_GAMEOVER = 2'd3
    } screen_t;

    // Menu button boxes, inclusive bounds; the menu renderer draws from the same numbers.
    localparam int MENU_BOX_X0   = 362;
    localparam int MENU_BOX_X1   = 674;
    localparam int MENU_START_Y0 = 46;
    localparam int MENU_START_Y1 = 146;
    localparam int MENU_CRED_Y0  = 622;
    localparam int MENU_CRED_Y1  = 722;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser, stability-count debouncer and rising-edge pulse
module button_debounce #(
    parameter int CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int            CW   = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          meta_q, sync_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // The count only survives while the synchronised input disagrees with the accepted level.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync_q;
                press_d = sync_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - selects the active Pong screen, committing changes only at frame boundaries
module screen_sequencer
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65000,
    parameter int GAMEOVER_FRAMES = 180,
    parameter int BOX_X0          = MENU_BOX_X0,
    parameter int BOX_X1          = MENU_BOX_X1,
    parameter int START_Y0        = MENU_START_Y0,
    parameter int START_Y1        = MENU_START_Y1,
    parameter int CRED_Y0         = MENU_CRED_Y0,
    parameter int CRED_Y1         = MENU_CRED_Y1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        button,
    input  logic        game_over,
    output logic [1:0]  screen_sel,
    output logic        game_start,
    output logic        game_rst,
    output logic        frame_tick
);

    localparam logic [11:0] X0  = 12'(BOX_X0);
    localparam logic [11:0] X1  = 12'(BOX_X1);
    localparam logic [11:0] SY0 = 12'(START_Y0);
    localparam logic [11:0] SY1 = 12'(START_Y1);
    localparam logic [11:0] CY0 = 12'(CRED_Y0);
    localparam logic [11:0] CY1 = 12'(CRED_Y1);

    localparam int             FCW     = $clog2(GAMEOVER_FRAMES + 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(GAMEOVER_FRAMES - 1);
    localparam logic [FCW-1:0] FC_MAX  = FCW'(GAMEOVER_FRAMES);

    logic           vblnk_q, frame_tick_q;
    logic           m_meta_q, m_sync_q, m_prev_q;
    screen_t        scr_q, scr_d;
    screen_t        pend_q, pend_d;
    logic           pend_vld_q, pend_vld_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           game_start_q, game_start_d;
    logic           game_rst_q, game_rst_d;

    logic    fb, click, press, in_x, in_start, in_cred;
    logic    req_vld;
    screen_t req_tgt;

    button_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_button_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (button),
        .press_o (press)
    );

    assign fb       = vblnk_in & ~vblnk_q;
    assign click    = m_sync_q & ~m_prev_q;
    assign in_x     = (xpos >= X0) && (xpos <= X1);
    assign in_start = in_x && (ypos >= SY0) && (ypos <= SY1);
    assign in_cred  = in_x && (ypos >= CY0) && (ypos <= CY1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            m_meta_q     <= 1'b0;
            m_sync_q     <= 1'b0;
            m_prev_q     <= 1'b0;
            scr_q        <= SCR_MENU;
            pend_q       <= SCR_MENU;
            pend_vld_q   <= 1'b0;
            fcnt_q       <= '0;
            game_start_q <= 1'b0;
            game_rst_q   <= 1'b1;
        end else begin
            vblnk_q      <= vblnk_in;
            frame_tick_q <= fb;
            m_meta_q     <= mouse_left;
            m_sync_q     <= m_meta_q;
            m_prev_q     <= m_sync_q;
            scr_q        <= scr_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            fcnt_q       <= fcnt_d;
            game_start_q <= game_start_d;
            game_rst_q   <= game_rst_d;
        end
    end

    always_comb begin
        req_vld      = 1'b0;
        req_tgt      = SCR_MENU;
        scr_d        = scr_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        fcnt_d       = fcnt_q;

        case (scr_q)
            SCR_MENU: begin
                if (click && in_start) begin
                    req_vld = 1'b1;
                    req_tgt = SCR_GAME;
                end else if (click && in_cred) begin
                    req_vld = 1'b1;
                    req_tgt = SCR_CREDITS;
                end
            end
            SCR_GAME: begin
                if (press) begin
                    req_vld = 1'b1;
                end else if (game_over) begin
                    req_vld = 1'b1;
                    req_tgt = SCR_GAMEOVER;
                end
            end
            SCR_CREDITS:  req_vld = press;
            SCR_GAMEOVER: req_vld = press || (fcnt_q == FC_LAST);
            default:      req_vld = 1'b0;
        endcase

        if (fb && pend_vld_q) begin
            scr_d      = pend_q;
            pend_vld_d = 1'b0;
        end
        // A request raised on the boundary cycle lands in pending after the commit, so it waits a frame.
        if (req_vld && (req_tgt != scr_q)) begin
            pend_d     = req_tgt;
            pend_vld_d = 1'b1;
        end

        if ((scr_d == SCR_GAMEOVER) && (scr_q != SCR_GAMEOVER)) begin
            fcnt_d = '0;
        end else if ((scr_q == SCR_GAMEOVER) && fb && (fcnt_q != FC_MAX)) begin
            fcnt_d = fcnt_q + FCW'(1);
        end

        game_start_d = (scr_d == SCR_GAME) && (scr_q != SCR_GAME);
        game_rst_d   = (scr_d != SCR_GAME);
    end

    assign screen_sel = scr_q;
    assign game_start = game_start_q;
    assign game_rst   = game_rst_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - table, directed and randomised checks of screen_sequencer against a screen-level model
module tb_screen_sequencer;

    localparam int DB   = 16;
    localparam int GOF  = 4;
    localparam int MENU = 0, GAME = 1, CRED = 2, GOV = 3;
    localparam int K_NONE = 0, K_CLICK = 1, K_HOLD = 2, K_GO = 3, K_BOUNCE = 4;
    localparam int NV = 30;

    typedef struct {
        int kind;
        int x;
        int y;
        int len;
        int exp_scr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, vblnk_in, mouse_left, button, game_over;
    logic [11:0] xpos, ypos;
    logic [1:0]  screen_sel;
    logic        game_start, game_rst, frame_tick;

    int checks = 0;
    int errors = 0;
    int m_scr, m_pend, m_cnt;
    vec_t tbl [NV];
    int xs [9]  = '{361, 362, 363, 500, 673, 674, 675, 0, 4095};
    int ys [15] = '{45, 46, 47, 100, 145, 146, 147, 400, 621, 622, 623, 700, 721, 722, 723};

    screen_sequencer #(
        .DEBOUNCE_CYCLES (DB),
        .GAMEOVER_FRAMES (GOF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .mouse_left (mouse_left),
        .button     (button),
        .game_over  (game_over),
        .screen_sel (screen_sel),
        .game_start (game_start),
        .game_rst   (game_rst),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);
    endtask

    task automatic do_click(input int x, input int y);
        xpos = 12'(x);
        ypos = 12'(y);
        step(1);
        mouse_left = 1'b1;
        step(4);
        mouse_left = 1'b0;
        step(4);
    endtask

    task automatic do_hold(input int len);
        button = 1'b1;
        step(len);
        button = 1'b0;
        step(DB + 6);
    endtask

    task automatic do_bounce();
        for (int i = 0; i < 10; i++) begin
            button = 1'b1;
            step(2);
            button = 1'b0;
            step(2);
        end
        button = 1'b1;
        step(DB + 8);
        button = 1'b0;
        step(DB + 6);
    endtask

    task automatic do_go();
        game_over = 1'b1;
        step(3);
        game_over = 1'b0;
        step(2);
    endtask

    // Raises vblnk_in, then checks the committed screen and the outputs that follow it.
    task automatic fb_check(input string nm, input int old_scr, input int exp);
        chk({nm, ":held"}, int'(screen_sel), old_scr);
        vblnk_in = 1'b1;
        step(1);
        chk({nm, ":screen_sel"}, int'(screen_sel), exp);
        chk({nm, ":frame_tick"}, int'(frame_tick), 1);
        chk({nm, ":game_start"}, int'(game_start), (exp == GAME && old_scr != GAME) ? 1 : 0);
        chk({nm, ":game_rst"}, int'(game_rst), (exp != GAME) ? 1 : 0);
        step(1);
        chk({nm, ":frame_tick_end"}, int'(frame_tick), 0);
        chk({nm, ":game_start_end"}, int'(game_start), 0);
        vblnk_in = 1'b0;
        step(2);
    endtask

    function automatic int click_tgt(input int scr, input int x, input int y);
        if (scr != MENU) return -1;
        if (x >= 362 && x <= 674 && y >= 46 && y <= 146) return GAME;
        if (x >= 362 && x <= 674 && y >= 622 && y <= 722) return CRED;
        return -1;
    endfunction

    function automatic int press_tgt(input int scr);
        return (scr == MENU) ? -1 : MENU;
    endfunction

    function automatic int go_tgt(input int scr);
        return (scr == GAME) ? GOV : -1;
    endfunction

    task automatic m_req(input int t);
        if (t >= 0 && t != m_scr) m_pend = t;
    endtask

    task automatic m_fb();
        int old;
        old = m_scr;
        if (m_pend >= 0) begin
            m_scr  = m_pend;
            m_pend = -1;
        end
        if (m_scr == GOV && old != GOV) m_cnt = 0;
        else if (old == GOV && m_cnt < GOF) m_cnt++;
        if (m_scr == GOV && m_cnt == GOF - 1) m_pend = MENU;
    endtask

    initial begin
        int prev, nev, kind, x, y, len, old;

        rst = 1'b1; vblnk_in = 1'b0; mouse_left = 1'b0; button = 1'b0; game_over = 1'b0;
        xpos = '0; ypos = '0;

        tbl = '{
            '{K_NONE,     0,    0,  0, MENU}, '{K_CLICK,  500,  100,  0, GAME},
            '{K_HOLD,     0,    0,  8, GAME}, '{K_HOLD,     0,    0, 15, GAME},
            '{K_HOLD,     0,    0, 16, MENU}, '{K_CLICK,  500,  400,  0, MENU},
            '{K_NONE,     0,    0,  0, MENU}, '{K_NONE,     0,    0,  0, MENU},
            '{K_CLICK,  361,  100,  0, MENU}, '{K_CLICK,  363,  147,  0, MENU},
            '{K_CLICK,  673,  621,  0, MENU}, '{K_CLICK,  674,  723,  0, MENU},
            '{K_CLICK,  674,  722,  0, CRED}, '{K_CLICK,  500,  100,  0, CRED},
            '{K_GO,       0,    0,  0, CRED}, '{K_HOLD,     0,    0, 30, MENU},
            '{K_CLICK,  362,   46,  0, GAME}, '{K_BOUNCE,   0,    0,  0, MENU},
            '{K_CLICK,  674,  146,  0, GAME}, '{K_GO,       0,    0,  0, GOV},
            '{K_NONE,     0,    0,  0, GOV},  '{K_NONE,     0,    0,  0, GOV},
            '{K_NONE,     0,    0,  0, GOV},  '{K_NONE,     0,    0,  0, MENU},
            '{K_CLICK,  500,  700,  0, CRED}, '{K_HOLD,     0,    0, 30, MENU},
            '{K_CLICK, 4095, 4095,  0, MENU}, '{K_CLICK,  400,  100,  0, GAME},
            '{K_GO,       0,    0,  0, GOV},  '{K_HOLD,     0,    0, 30, MENU}
        };

        step(3);
        chk("reset:screen_sel", int'(screen_sel), MENU);
        chk("reset:game_rst", int'(game_rst), 1);
        rst = 1'b0;
        step(3);
        chk("reset:game_start", int'(game_start), 0);
        chk("reset:frame_tick", int'(frame_tick), 0);
        chk("reset:game_rst_after", int'(game_rst), 1);

        prev = MENU;
        for (int i = 0; i < NV; i++) begin
            case (tbl[i].kind)
                K_CLICK:  do_click(tbl[i].x, tbl[i].y);
                K_HOLD:   do_hold(tbl[i].len);
                K_GO:     do_go();
                K_BOUNCE: do_bounce();
                default:  step(4);
            endcase
            step(3);
            fb_check($sformatf("vec%0d", i), prev, tbl[i].exp_scr);
            prev = tbl[i].exp_scr;
        end

        // Press and game_over in the very same cycle: the press must win.
        do_click(500, 100);
        step(3);
        fb_check("both_enter", MENU, GAME);
        button = 1'b1;
        step(DB + 2);
        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        step(4);
        button = 1'b0;
        step(DB + 6);
        fb_check("both_same_cycle", GAME, MENU);

        // Click detected on the same cycle as the vblnk_in rise waits one frame.
        xpos = 12'd500;
        ypos = 12'd100;
        step(1);
        mouse_left = 1'b1;
        step(2);
        vblnk_in = 1'b1;
        step(1);
        chk("fbclick:screen_sel", int'(screen_sel), MENU);
        chk("fbclick:frame_tick", int'(frame_tick), 1);
        mouse_left = 1'b0;
        vblnk_in = 1'b0;
        step(6);
        fb_check("fbclick_next", MENU, GAME);

        do_reset();
        m_scr = MENU; m_pend = -1; m_cnt = 0;
        for (int it = 0; it < 80; it++) begin
            old = m_scr;
            nev = $urandom_range(0, 2);
            for (int e = 0; e < nev; e++) begin
                kind = $urandom_range(0, 3);
                if (kind <= 1) begin
                    x = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4095) : xs[$urandom_range(0, 8)];
                    y = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4095) : ys[$urandom_range(0, 14)];
                    m_req(click_tgt(m_scr, x, y));
                    do_click(x, y);
                end else if (kind == 2) begin
                    len = ($urandom_range(0, 2) != 0) ? DB + $urandom_range(0, 6) : $urandom_range(1, DB - 1);
                    if (len >= DB) m_req(press_tgt(m_scr));
                    do_hold(len);
                end else begin
                    m_req(go_tgt(m_scr));
                    do_go();
                end
            end
            step(3);
            m_fb();
            fb_check($sformatf("rnd%0d", it), old, m_scr);
        end

        // Reset with a request pending and the debouncer mid-count.
        do_reset();
        do_click(500, 100);
        step(3);
        fb_check("rst_enter", MENU, GAME);
        game_over = 1'b1;
        step(3);
        game_over = 1'b0;
        step(2);
        button = 1'b1;
        step(DB / 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst:screen_sel", int'(screen_sel), MENU);
        chk("midrst:game_rst", int'(game_rst), 1);
        chk("midrst:game_start", int'(game_start), 0);
        chk("midrst:frame_tick", int'(frame_tick), 0);
        button = 1'b0;
        step(3);
        @(negedge clk);
        rst = 1'b0;
        step(DB + 6);
        fb_check("rst_no_survivor", MENU, MENU);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
